// File: rtl/i2c_master_bit_engine_if.sv
// Command handshake and open-drain pad bundle for i2c_master_bit_engine.
// master = sequencer/pad side, slave = the bit engine.
interface i2c_master_bit_engine_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd;
    logic [7:0] wr_data;
    logic       rd_nack;
    logic [7:0] rd_data;
    logic       ack_rx;
    logic       done;
    logic       scl_in;
    logic       sda_in;
    logic       scl_oe;
    logic       sda_oe;

    modport master (
        output cmd_valid, cmd, wr_data, rd_nack, scl_in, sda_in,
        input  cmd_ready, rd_data, ack_rx, done, scl_oe, sda_oe
    );

    modport slave (
        input  cmd_valid, cmd, wr_data, rd_nack, scl_in, sda_in,
        output cmd_ready, rd_data, ack_rx, done, scl_oe, sda_oe
    );
endinterface

// File: rtl/i2c_master_bit_engine.sv
// Bit-level I2C initiator: START/STOP/WRITE/READ in 4 quarter phases per bit.
// Define I2C_CLK_STRETCH_EN to hold the Q1 timer until scl_in reads high.
module i2c_master_bit_engine #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic                  clk,
    input  logic                  reset,
    i2c_master_bit_engine_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_STOP  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

    logic [2:0]  state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic        nack_q, nack_d;
    logic        scl_q, scl_d;
    logic        sda_q, sda_d;
    logic        acks_q, acks_d;
    logic        ack_q, ack_d;
    logic [7:0]  rd_q, rd_d;
    logic        done_q, done_d;
    logic        rdy_q, rdy_d;
    logic        run;
    logic        tick;
    logic        last_bit;
    logic        is_wr;

`ifdef I2C_CLK_STRETCH_EN
    assign run = !(phase_q == 2'd1 && !bus.scl_in);
`else
    assign run = 1'b1;
`endif

    assign tick     = run && (cnt_q == DIV_M1);
    assign last_bit = (bit_q == 4'd8);
    assign is_wr    = (state_q == S_WRITE);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        nack_d  = nack_q;
        scl_d   = scl_q;
        sda_d   = sda_q;
        acks_d  = acks_q;
        ack_d   = ack_q;
        rd_d    = rd_q;
        done_d  = 1'b0;
        rdy_d   = rdy_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid && rdy_q) begin
                    rdy_d   = 1'b0;
                    phase_d = 2'd0;
                    cnt_d   = 16'd0;
                    bit_d   = 4'd0;
                    sh_d    = bus.wr_data;
                    nack_d  = bus.rd_nack;
                    unique case (bus.cmd)
                        3'd0: begin
                            state_d = S_START;
                            sda_d   = 1'b0;
                        end
                        3'd1: begin
                            state_d = S_STOP;
                            sda_d   = 1'b1;
                        end
                        3'd2: begin
                            state_d = S_WRITE;
                            scl_d   = 1'b1;
                            sda_d   = ~bus.wr_data[7];
                        end
                        3'd3: begin
                            state_d = S_READ;
                            scl_d   = 1'b1;
                            sda_d   = 1'b0;
                        end
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_START, S_STOP, S_WRITE, S_READ: begin
                if (run && !tick) begin
                    cnt_d = cnt_q + 16'd1;
                end else if (tick) begin
                    cnt_d   = 16'd0;
                    phase_d = phase_q + 2'd1;
                    unique case (phase_q)
                        2'd0: scl_d = 1'b0;
                        2'd1: begin
                            if (state_q == S_START) begin
                                sda_d = 1'b1;
                            end else if (state_q == S_STOP) begin
                                sda_d = 1'b0;
                            end else if (!last_bit) begin
                                sh_d = {sh_q[6:0], bus.sda_in};
                            end else begin
                                acks_d = bus.sda_in;
                            end
                        end
                        2'd2: begin
                            if (state_q != S_STOP) scl_d = 1'b1;
                        end
                        default: begin
                            // Data bits change only here, with SCL already held low
                            if (state_q == S_START || state_q == S_STOP
                                || last_bit) begin
                                state_d = S_DONE;
                                if (is_wr) ack_d = acks_q;
                                if (state_q == S_READ) rd_d = sh_q;
                            end else begin
                                bit_d = bit_q + 4'd1;
                                if (is_wr) begin
                                    sda_d = (bit_q == 4'd7) ? 1'b0 : ~sh_q[7];
                                end else begin
                                    sda_d = (bit_q == 4'd7) ? ~nack_q : 1'b0;
                                end
                            end
                        end
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (done_q) rdy_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            phase_q <= 2'd0;
            cnt_q   <= 16'd0;
            bit_q   <= 4'd0;
            sh_q    <= 8'h00;
            nack_q  <= 1'b0;
            scl_q   <= 1'b0;
            sda_q   <= 1'b0;
            acks_q  <= 1'b0;
            ack_q   <= 1'b0;
            rd_q    <= 8'h00;
            done_q  <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            nack_q  <= nack_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            acks_q  <= acks_d;
            ack_q   <= ack_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
            rdy_q   <= rdy_d;
        end
    end

    assign bus.cmd_ready = rdy_q;
    assign bus.done      = done_q;
    assign bus.scl_oe    = scl_q;
    assign bus.sda_oe    = sda_q;
    assign bus.rd_data   = rd_q;
    assign bus.ack_rx    = ack_q;
endmodule

// File: doc/i2c_master_bit_engine.md
# i2c_master_bit_engine

Bit-level I2C initiator: the controller-side counterpart of the team's responder bit interface. It generates SCL, START, repeated-START and STOP conditions, shifts bytes out on SDA, samples the responder's ACK, and shifts bytes in with a caller-chosen ACK/NACK. It sits between a byte-command sequencer (register-write FSM for the LED driver) and the open-drain pads. Both lines are driven only low or released.

## Interface
- CLK_DIV, 16'd125: system clocks per quarter SCL period; legal range 2..65535 (100 kHz SCL at 50 MHz clk).
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  engine idle and able to accept a command
- cmd  in  3  3'd0 START, 3'd1 STOP, 3'd2 WRITE, 3'd3 READ; 3'd4-3'd7 reserved
- wr_data  in  8  byte for WRITE, captured on acceptance
- rd_nack  in  1  READ only: 1 = release SDA (NACK) on the 9th bit, 0 = drive ACK
- rd_data  out  8  byte from the last READ
- ack_rx  out  1  SDA sampled on the 9th bit of the last WRITE (0 = ACK)
- done  out  1  one-cycle pulse when a command completes
- scl_in / sda_in  in  1 each  pad readback
- scl_oe / sda_oe  out  1 each  1 = pull line low, 0 = release

## Operation
- Handshake: command is accepted on a clk edge with cmd_valid && cmd_ready. wr_data, rd_nack and cmd are latched at acceptance. cmd_ready drops the next cycle and stays low until the cycle after done.
- Quarter timer: a 16-bit counter counts CLK_DIV clocks per phase. Each bit has 4 phases, Q0..Q3.
- States: IDLE, START, STOP, WRITE, READ, DONE.
- START phases:
  - Q0: release SDA, keep SCL state.
  - Q1: release SCL.
  - Q2: pull SDA low.
  - Q3: pull SCL low.
  - Also valid as a repeated START after WRITE/READ, because SCL is low at entry.
- STOP phases:
  - Q0: pull SDA low.
  - Q1: release SCL.
  - Q2: release SDA.
  - Q3: hold. The bus ends idle, with both lines released.
- WRITE: 9 bits, MSB first, bit counter 0..8.
  - Q0: SCL low; sda_oe = ~data bit. On bit 8, SDA is released.
  - Q1: release SCL.
  - Q2: mid-high. On bit 8, sample sda_in into ack_rx.
  - Q3: pull SCL low.
- READ: same phases, but SDA is released for bits 0..7.
  - Q2 of bits 0..7: shift sda_in into a shift register, MSB first.
  - Bit 8, Q0: sda_oe = ~rd_nack.
  - After Q3 of bit 8: rd_data is updated from the shift register.
- DONE: asserts done for one cycle, then returns to IDLE.
- Reserved cmd codes: accepted, no bus activity, done pulses the cycle after acceptance.
- The engine does not track bus ownership. Commands are executed as issued; sequencing legality belongs to the sequencer.
- Reset mid-operation: scl_oe and sda_oe release asynchronously, and the FSM returns to IDLE. No STOP is generated.

## Timing
- Reset values: cmd_ready=1, done=0, scl_oe=0, sda_oe=0, rd_data=8'h00, ack_rx=0.
- Latency, acceptance edge to done high:
  - START / STOP: 4*CLK_DIV+1 cycles.
  - WRITE / READ: 36*CLK_DIV+1 cycles.
  - Reserved cmd: 1 cycle.
- Back-to-back: with cmd_valid held high, the next command is accepted 2 cycles after the done pulse.
- scl_oe and sda_oe are registered outputs; they change only on phase boundaries.
- SDA never changes while SCL is released, except in the START Q2 and STOP Q2 phases.
- ack_rx and rd_data are valid from the done pulse until the next WRITE or READ completes.

## Configuration
- I2C_CLK_STRETCH_EN defined: the Q1 timer does not begin counting until the engine reads scl_in==1. This supports responder clock stretching. Every bit, START and STOP is lengthened by the stretch time.
- Not defined: scl_in is ignored and all phases are exactly CLK_DIV clocks.

## Test plan
- Reset while READ is in bit 4 -> scl_oe=0, sda_oe=0, cmd_ready=1 and done=0 within one clk of reset assertion. After release, a START completes normally.
- CLK_DIV=4:
  - START -> sda_oe rises at cycle 8 after acceptance, scl_oe at cycle 12; done at cycle 17.
  - Then WRITE 0xA5 with the responder pulling SDA low on bit 8 -> SDA bits observed at SCL rise are 1,0,1,0,0,1,0,1; ack_rx=0; done 145 cycles after acceptance.
- WRITE 0x3C with SDA left released on the 9th bit -> ack_rx=1; NACK case.
- READ, responder drives 0x5A, rd_nack=1 -> rd_data=8'h5A. SDA is released during the 9th SCL high.
  - Repeat with rd_nack=0 -> sda_oe=1 during the 9th bit.
- STOP after WRITE -> SDA rises while SCL high; both lines released at done.
  - Then cmd=3'd6 -> done 1 cycle later, no pad toggles.
- With I2C_CLK_STRETCH_EN, responder holds SCL low 50 clks on bit 3 of a WRITE (CLK_DIV=4) -> done at 195 cycles, no SDA change while scl_in low.
